// File: rtl/hyst_pkg.sv
// ----------------------------------------------------------------------------
// hyst_pkg
// Shared types and constants for the hysteresis tracker.
//   pix_class_e : 2-bit pixel class held in the line buffers (NONE/WEAK/STRONG)
//   state_e     : frame-sequencing FSM states (RUN/FLUSH/DONE)
//   EDGE_ON / EDGE_OFF : binary edge-map output codes
//   classify()  : maps a threshold-stage byte to its class
// ----------------------------------------------------------------------------
package hyst_pkg;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_WEAK   = 2'd1,
      CLS_STRONG = 2'd2
   } pix_class_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [7:0] EDGE_ON  = 8'hFF;
   localparam logic [7:0] EDGE_OFF = 8'h00;

   // The strong code is checked first so that a strong code of zero
   // would still classify as strong rather than none.
   function automatic pix_class_e classify(input logic [7:0] pix,
                                           input logic [7:0] strong_val);
      if (pix == strong_val) begin
         return CLS_STRONG;
      end else if (pix == 8'h00) begin
         return CLS_NONE;
      end else begin
         return CLS_WEAK;
      end
   endfunction

endpackage

// File: rtl/hyst_line_buffer.sv
// ----------------------------------------------------------------------------
// hyst_line_buffer
// DEPTH-entry delay line of 2-bit pixel classes. Each shift_en pushes din in
// and the entry pushed DEPTH shifts ago appears on dout.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (contents -> NONE)
//   shift_en   : advance the line by one pixel
//   din        : class entering the line
//   dout       : class leaving the line (oldest entry)
// ----------------------------------------------------------------------------
module hyst_line_buffer
   import hyst_pkg::*;
#(
   parameter int unsigned DEPTH = 504
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_en,
   input  pix_class_e din,
   output pix_class_e dout
);

   logic [DEPTH-1:0][1:0] mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else if (shift_en) begin
         mem_q <= {mem_q[DEPTH-2:0], din};
      end
   end

   assign dout = pix_class_e'(mem_q[DEPTH-1]);

endmodule

// File: rtl/hysteresis_tracker.sv
// ----------------------------------------------------------------------------
// hysteresis_tracker
// Final Canny stage: 3x3 single-pass hysteresis over a raster stream of
// threshold codes. Weak pixels touching a strong neighbour become edges,
// strong pixels are always edges, everything else is cleared.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_pixel carries a threshold code
//   in_pixel    : STRONG_VAL = strong, 0 = none, other = weak
//   in_ready    : pixel accepted when in_valid && in_ready
//   out_valid   : out_pixel valid this cycle
//   out_pixel   : 8'hFF edge / 8'h00 no edge
//   frame_done  : one-cycle pulse the cycle after the last output of a frame
// Optional build macro HYST_STATS_EN adds stat_strong, stat_promoted and
// stat_suppressed per-frame counters.
//
// Handshake: the input is a valid/ready interface; a pixel transfers on any
// rising edge where in_valid && in_ready. in_ready depends only on the FSM
// state. The output has no back-pressure: out_valid is a one-cycle strobe.
// ----------------------------------------------------------------------------
module hysteresis_tracker
   import hyst_pkg::*;
#(
   parameter int unsigned WIDTH      = 504,
   parameter int unsigned HEIGHT     = 504,
   parameter logic [7:0]  STRONG_VAL = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_pixel,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_pixel,
   output logic        frame_done
`ifdef HYST_STATS_EN
   ,
   output logic [31:0] stat_strong,
   output logic [31:0] stat_promoted,
   output logic [31:0] stat_suppressed
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned RW = $clog2(HEIGHT);
   localparam int unsigned FW = $clog2(WIDTH + 2);

   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
   localparam logic [FW-1:0] FILL_FULL  = FW'(WIDTH + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);

   // ---------------------------------------------------------------- state
   state_e          state_q, state_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic [CW-1:0]   col_q, col_d;      // position of next input pixel
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   ccol_q, ccol_d;    // position of current window center
   logic [RW-1:0]   crow_q, crow_d;
   logic [FW-1:0]   fill_q, fill_d;    // pixels shifted in, saturating

   // Window: a = one pixel behind the newest column, b = two behind.
   pix_class_e      w0a_q, w0b_q, w1a_q, w1b_q, w2a_q, w2b_q;
   pix_class_e      lb0_out, lb1_out;

   logic            out_valid_q;
   logic [7:0]      out_pixel_q;
   logic            frame_done_q;

   // FSM outputs
   logic            flush_step;
   logic            frame_start;

   // datapath
   logic            accept;
   logic            step;
   logic            produce;
   logic            last_in;
   pix_class_e      new_cls;
   logic [CW-1:0]   col_b, ccol_b;
   logic [RW-1:0]   row_b, crow_b;
   logic [FW-1:0]   fill_b;
   logic            m_top, m_bot, m_left, m_right;
   logic            nb_strong;
   logic            is_edge;
   logic            ctr_is_strong, ctr_is_promoted, ctr_is_suppressed;

   // ------------------------------------------------ FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
      end
   end

   // ------------------------------------------------ FSM: next state
   always_comb begin
      state_d = state_q;
      flush_d = '0;
      case (state_q)
         ST_RUN: begin
            if (last_in) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush_d = flush_q + FW'(1);
            if (flush_q == FLUSH_LAST) begin
               state_d = ST_DONE;
               flush_d = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // ------------------------------------------------ FSM: outputs
   // DONE keeps in_ready high: a pixel arriving then is pixel (0,0) of the
   // next frame, which lets frames stream back-to-back.
   always_comb begin
      in_ready    = 1'b0;
      flush_step  = 1'b0;
      frame_start = 1'b0;
      case (state_q)
         ST_RUN:   in_ready = 1'b1;
         ST_FLUSH: flush_step = 1'b1;
         ST_DONE: begin
            in_ready    = 1'b1;
            frame_start = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // ------------------------------------------------ stream control
   assign accept  = in_valid && in_ready;
   assign step    = accept || flush_step;
   assign new_cls = flush_step ? CLS_NONE : classify(in_pixel, STRONG_VAL);

   // In DONE every counter reads as zero, so a pixel accepted there starts
   // the new frame from a clean base.
   assign col_b  = frame_start ? '0 : col_q;
   assign row_b  = frame_start ? '0 : row_q;
   assign ccol_b = frame_start ? '0 : ccol_q;
   assign crow_b = frame_start ? '0 : crow_q;
   assign fill_b = frame_start ? '0 : fill_q;

   assign last_in = accept && (col_b == COL_LAST) && (row_b == ROW_LAST);
   assign produce = step && (fill_b == FILL_FULL);

   always_comb begin
      col_d  = col_b;
      row_d  = row_b;
      ccol_d = ccol_b;
      crow_d = crow_b;
      fill_d = fill_b;
      if (accept) begin
         if (col_b == COL_LAST) begin
            col_d = '0;
            row_d = (row_b == ROW_LAST) ? '0 : row_b + RW'(1);
         end else begin
            col_d = col_b + CW'(1);
         end
      end
      if (step && (fill_b != FILL_FULL)) begin
         fill_d = fill_b + FW'(1);
      end
      if (produce) begin
         if (ccol_b == COL_LAST) begin
            ccol_d = '0;
            crow_d = (crow_b == ROW_LAST) ? '0 : crow_b + RW'(1);
         end else begin
            ccol_d = ccol_b + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         ccol_q <= '0;
         crow_q <= '0;
         fill_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         ccol_q <= ccol_d;
         crow_q <= crow_d;
         fill_q <= fill_d;
      end
   end

   // ------------------------------------------------ line buffers
   hyst_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (step),
      .din      (new_cls),
      .dout     (lb0_out)
   );

   hyst_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (step),
      .din      (lb0_out),
      .dout     (lb1_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0a_q <= CLS_NONE;
         w0b_q <= CLS_NONE;
         w1a_q <= CLS_NONE;
         w1b_q <= CLS_NONE;
         w2a_q <= CLS_NONE;
         w2b_q <= CLS_NONE;
      end else if (step) begin
         w0b_q <= w0a_q;
         w0a_q <= lb1_out;
         w1b_q <= w1a_q;
         w1a_q <= lb0_out;
         w2b_q <= w2a_q;
         w2a_q <= new_cls;
      end
   end

   // ------------------------------------------------ decision
   // The window's right column is the live tap (line-buffer outputs and the
   // incoming class); the center is w1a_q. Border masks stop neighbours
   // leaking in from the previous line, previous frame or flush padding.
   always_comb begin
      m_top   = (crow_b == '0);
      m_bot   = (crow_b == ROW_LAST);
      m_left  = (ccol_b == '0);
      m_right = (ccol_b == COL_LAST);

      nb_strong = 1'b0;
      if (!m_top) begin
         if (!m_left  && (w0b_q   == CLS_STRONG)) nb_strong = 1'b1;
         if (            w0a_q   == CLS_STRONG ) nb_strong = 1'b1;
         if (!m_right && (lb1_out == CLS_STRONG)) nb_strong = 1'b1;
      end
      if (!m_left  && (w1b_q   == CLS_STRONG)) nb_strong = 1'b1;
      if (!m_right && (lb0_out == CLS_STRONG)) nb_strong = 1'b1;
      if (!m_bot) begin
         if (!m_left  && (w2b_q   == CLS_STRONG)) nb_strong = 1'b1;
         if (            w2a_q   == CLS_STRONG ) nb_strong = 1'b1;
         if (!m_right && (new_cls == CLS_STRONG)) nb_strong = 1'b1;
      end

      ctr_is_strong     = (w1a_q == CLS_STRONG);
      ctr_is_promoted   = (w1a_q == CLS_WEAK) && nb_strong;
      ctr_is_suppressed = (w1a_q == CLS_WEAK) && !nb_strong;
      is_edge           = ctr_is_strong || ctr_is_promoted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_pixel_q  <= EDGE_OFF;
         frame_done_q <= 1'b0;
      end else begin
         out_valid_q  <= produce;
         frame_done_q <= frame_start;
         if (produce) begin
            out_pixel_q <= is_edge ? EDGE_ON : EDGE_OFF;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pixel  = out_pixel_q;
   assign frame_done = frame_done_q;

`ifdef HYST_STATS_EN
   // ------------------------------------------------ per-frame statistics
   // Totals stay visible after a frame ends; the first output of the next
   // frame restarts them from zero before counting itself.
   logic [31:0] stat_strong_q, stat_promoted_q, stat_suppressed_q;
   logic        stat_clr_pend_q;
   logic [31:0] strong_b, promoted_b, suppressed_b;

   assign strong_b     = stat_clr_pend_q ? 32'd0 : stat_strong_q;
   assign promoted_b   = stat_clr_pend_q ? 32'd0 : stat_promoted_q;
   assign suppressed_b = stat_clr_pend_q ? 32'd0 : stat_suppressed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_strong_q     <= '0;
         stat_promoted_q   <= '0;
         stat_suppressed_q <= '0;
         stat_clr_pend_q   <= 1'b0;
      end else begin
         if (produce) begin
            stat_strong_q     <= strong_b     + {31'd0, ctr_is_strong};
            stat_promoted_q   <= promoted_b   + {31'd0, ctr_is_promoted};
            stat_suppressed_q <= suppressed_b + {31'd0, ctr_is_suppressed};
            stat_clr_pend_q   <= 1'b0;
         end else if (frame_start) begin
            stat_clr_pend_q   <= 1'b1;
         end
      end
   end

   assign stat_strong     = stat_strong_q;
   assign stat_promoted   = stat_promoted_q;
   assign stat_suppressed = stat_suppressed_q;
`endif

endmodule

// File: tb/tb_hysteresis_tracker.sv
module tb_hysteresis_tracker;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  // ---------------------------------------------------------- clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       frame_done;
`ifdef HYST_STATS_EN
  logic [31:0] stat_strong, stat_promoted, stat_suppressed;
`endif

  always #5 clk = ~clk;

  hysteresis_tracker #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .STRONG_VAL (8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .frame_done (frame_done)
`ifdef HYST_STATS_EN
    ,
    .stat_strong     (stat_strong),
    .stat_promoted   (stat_promoted),
    .stat_suppressed (stat_suppressed)
`endif
  );

  // ---------------------------------------------------------- bookkeeping
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frm [H][W];
  logic [7:0] got_px [N];
  logic [7:0] ref_px [N];

  int cyc = 0;
  int pushed_cnt = 0;
  int out_cnt = 0;
  int out_idx = 0;
  int first_xfer_cyc = -1;
  int first_out_cyc = -1;
  int last_out_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rdy_low = 0;
  bit ignore_out = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  function automatic logic [7:0] model_px(input int r, input int c);
    logic [7:0] p;
    p = frm[r][c];
    if (p == 8'hFF) return 8'hFF;
    if (p == 8'h00) return 8'h00;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < H) &&
            (c + dc >= 0) && (c + dc < W)) begin
          if (frm[r+dr][c+dc] == 8'hFF) return 8'hFF;
        end
      end
    end
    return 8'h00;
  endfunction

  // ---------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) rdy_low++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && !ignore_out) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
        got_px[out_idx] = out_pixel;
        if (exp_q.size() == 0) begin
          check_val("out_count", out_cnt, pushed_cnt);
        end else begin
          check_val($sformatf("pix%0d", out_idx), out_pixel, exp_q.pop_front());
        end
        out_idx = (out_idx + 1) % N;
      end
    end
  end

  // ---------------------------------------------------------- drivers
  task automatic drive_px(input logic [7:0] p, input int gap_pct);
    int budget;
    budget = 0;
    while (gap_pct > 0 && budget < 8 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b1;
    in_pixel = p;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check_val("ready_timeout", {31'd0, in_ready}, 32'd1);
    if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_frame(input int gap_pct);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_q.push_back(model_px(r, c));
        pushed_cnt++;
      end
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive_px(frm[r][c], gap_pct);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = 0;
    while (done_cnt < target && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check_val("frame_done_seen", done_cnt, target);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_frm();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frm[r][c] = 8'h00;
  endtask

  task automatic set_t3_frm();
    clear_frm();
    frm[2][3] = 8'h40;
    frm[3][4] = 8'hFF;
    frm[4][1] = 8'h40;
  endtask

  task automatic random_frm();
    int k;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        k = $urandom_range(0, 9);
        if (k < 5)      frm[r][c] = 8'h00;
        else if (k < 7) frm[r][c] = 8'hFF;
        else            frm[r][c] = 8'($urandom_range(1, 254));
      end
    end
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    int d0, o0, diffs;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_pixel", {24'd0, out_pixel}, 32'h00);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero frame: latency, flush length, done timing
    clear_frm();
    first_xfer_cyc = -1; first_out_cyc = -1; rdy_low = 0; out_idx = 0;
    d0 = done_cnt; o0 = out_cnt;
    send_frame(0);
    wait_frames(d0 + 1);
    repeat (5) @(negedge clk);
    check_val("first_out_latency", first_out_cyc - first_xfer_cyc, 32'd10);
    check_val("flush_ready_low", rdy_low, 32'd9);
    check_val("done_pulses", done_cnt - d0, 32'd1);
    check_val("done_after_last", done_cyc, last_out_cyc + 1);
    check_val("zero_out_count", out_cnt - o0, N);
    check_val("zero_q_empty", exp_q.size(), 32'd0);

    // weak next to strong, isolated weak
    set_t3_frm();
    out_idx = 0; d0 = done_cnt;
    send_frame(0);
    wait_frames(d0 + 1);
    check_val("t3_weak_promoted", got_px[2*W+3], 32'hFF);
    check_val("t3_strong", got_px[3*W+4], 32'hFF);
    check_val("t3_isolated_weak", got_px[4*W+1], 32'h00);
    for (int i = 0; i < N; i++) ref_px[i] = got_px[i];
`ifdef HYST_STATS_EN
    check_val("stat_strong", stat_strong, 32'd1);
    check_val("stat_promoted", stat_promoted, 32'd1);
    check_val("stat_suppressed", stat_suppressed, 32'd1);
`endif

    // no wrap across lines; bottom-right corner during flush
    clear_frm();
    frm[0][7] = 8'h40;
    frm[1][0] = 8'hFF;
    frm[5][7] = 8'h40;
    frm[4][6] = 8'hFF;
    out_idx = 0; d0 = done_cnt;
    send_frame(0);
    wait_frames(d0 + 1);
    check_val("wrap_right_edge", got_px[7], 32'h00);
    check_val("wrap_strong_left", got_px[8], 32'hFF);
    check_val("corner_flush", got_px[N-1], 32'hFF);

    // same frame with random input gaps
    set_t3_frm();
    out_idx = 0; d0 = done_cnt;
    send_frame(50);
    wait_frames(d0 + 1);
    diffs = 0;
    for (int i = 0; i < N; i++) if (got_px[i] !== ref_px[i]) diffs++;
    check_val("gap_vs_nogap", diffs, 32'd0);

    // two frames back-to-back
    out_idx = 0; d0 = done_cnt;
    set_t3_frm();
    send_frame(0);
    random_frm();
    send_frame(0);
    wait_frames(d0 + 2);
    check_val("b2b_q_empty", exp_q.size(), 32'd0);

    // reset in the middle of a frame, then a fresh full frame
    random_frm();
    ignore_out = 1'b1;
    for (int i = 0; i < 20; i++) drive_px(frm[i / W][i % W], 0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef HYST_STATS_EN
    check_val("mid_rst_stat", stat_strong, 32'd0);
`endif
    rst_n = 1'b1;
    exp_q.delete();
    pushed_cnt = 0; out_cnt = 0; out_idx = 0;
    ignore_out = 1'b0;
    @(negedge clk);
    random_frm();
    d0 = done_cnt;
    send_frame(25);
    wait_frames(d0 + 1);
    check_val("post_rst_out_count", out_cnt, N);
    check_val("post_rst_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
